// File: rtl/fsk_tone_sequencer.sv
// rtl/fsk_tone_sequencer.sv - byte-serial FSK tone generator, LSB first
//
// Accepts one byte through a valid/ready handshake and sends its eight bits
// LSB first. Each bit is a square wave lasting BIT_CYCLES clocks. A '1' bit
// uses half-period MARK_HALF and a '0' bit uses half-period SPACE_HALF.
// A single DONE cycle follows the last bit, and then the block returns to IDLE.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   din        byte to transmit, captured on handshake
//   din_valid  din holds a byte
//   din_ready  block accepts a byte this cycle (IDLE only)
//   fsk_out    FSK square-wave output
//   bit_out    data bit currently on air (0 outside SEND)
//   busy       high in SEND and DONE
//   done       one-cycle pulse after the last bit
module fsk_tone_sequencer #(
   parameter int MARK_HALF  = 3,
   parameter int SPACE_HALF = 6,
   parameter int BIT_CYCLES = 48,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       fsk_out,
   output logic       bit_out,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   localparam logic [CNT_W-1:0] MARK_LAST  = CNT_W'(MARK_HALF - 1);
   localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SPACE_HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);

   state_t            state;
   logic [7:0]        shreg;
   logic [2:0]        bit_idx;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  tone_cnt;

   logic [CNT_W-1:0]  half_last;
   logic              tone_hit;
   logic              bit_end;

   always_comb begin
      half_last = shreg[0] ? MARK_LAST : SPACE_LAST;
      tone_hit  = (tone_cnt == half_last);
      bit_end   = (bit_cnt == BIT_LAST);
   end

   // All outputs are registered. bit_out is loaded with the value that the
   // shift register LSB will hold in the next cycle, so it tracks the bit on air.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_idx   <= '0;
         bit_cnt   <= '0;
         tone_cnt  <= '0;
         fsk_out   <= 1'b0;
         bit_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         din_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (din_valid) begin
                  shreg     <= din;
                  bit_idx   <= '0;
                  bit_cnt   <= '0;
                  tone_cnt  <= '0;
                  fsk_out   <= 1'b0;
                  bit_out   <= din[0];
                  busy      <= 1'b1;
                  din_ready <= 1'b0;
                  state     <= SEND;
               end
            end

            SEND: begin
               if (tone_hit) begin
                  tone_cnt <= '0;
                  fsk_out  <= ~fsk_out;
               end else begin
                  tone_cnt <= tone_cnt + CNT_W'(1);
               end

               // The bit boundary restarts the tone phase, but a toggle that
               // falls on the same edge still happens above.
               if (bit_end) begin
                  bit_cnt  <= '0;
                  tone_cnt <= '0;
                  shreg    <= shreg >> 1;
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     bit_out <= 1'b0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     bit_out <= shreg[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            DONE: begin
               fsk_out   <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
               din_ready <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               din_ready <= 1'b1;
               fsk_out   <= 1'b0;
               bit_out   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsk_tone_sequencer.sv
// tb/tb_fsk_tone_sequencer.sv - self-checking bench for fsk_tone_sequencer
module tb_fsk_tone_sequencer;

   localparam int MH = 3;
   localparam int SH = 6;
   localparam int BC = 48;
   localparam int NB = 8 * BC;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       fsk_out;
   logic       bit_out;
   logic       busy;
   logic       done;

   fsk_tone_sequencer #(
      .MARK_HALF (MH),
      .SPACE_HALF(SH),
      .BIT_CYCLES(BC),
      .CNT_W     (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .din      (din),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .fsk_out  (fsk_out),
      .bit_out  (bit_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: m_k = -1 in IDLE, 0..NB-1 = SEND cycle index, NB = DONE.
   int         m_k    = -1;
   logic [7:0] m_byte = 8'h00;
   bit         chk_en = 1'b0;

   function automatic int half_of(input logic b);
      return b ? MH : SH;
   endfunction

   // fsk level during SEND cycle k: parity of the toggles already completed.
   // Each bit restarts its tone phase, so every finished bit contributes
   // BC/half toggles and the current bit contributes floor(pos/half).
   function automatic logic level(input logic [7:0] b, input int k);
      int t;
      t = 0;
      for (int i = 0; i < k / BC; i++) t += BC / half_of(b[i]);
      if (k < NB) t += (k % BC) / half_of(b[k / BC]);
      return t[0];
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) m_k = -1;
      else if (m_k < 0) begin
         if (din_valid) begin
            m_byte = din;
            m_k    = 0;
         end
      end else if (m_k >= NB) m_k = -1;
      else m_k++;
   end

   always @(negedge clk) begin
      logic [4:0] e_v;
      logic [4:0] a_v;
      if (chk_en) begin
         if (m_k < 0)       e_v = 5'b10000;
         else if (m_k < NB) e_v = {3'b010, m_byte[m_k / BC], level(m_byte, m_k)};
         else               e_v = {4'b0110, level(m_byte, NB)};
         a_v = {din_ready, busy, done, bit_out, fsk_out};
         checks++;
         if (a_v !== e_v) begin
            errors++;
            $display("FAIL cycle_model cyc=%0d k=%0d {rdy,busy,done,bit,fsk} act=%b exp=%b",
                     cyc, m_k, a_v, e_v);
         end
      end
   end

   task automatic check_int(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b, output int tog, output int ones,
                            output int busy_n, output int done_n);
      int   guard;
      logic prev_f;
      bit   prev_c;
      bit   seen;
      tog = 0; ones = 0; busy_n = 0; done_n = 0;
      din = b;
      din_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!din_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check_int("ready_wait", int'(guard < 1000), 1);
      prev_f = fsk_out;
      prev_c = 1'b1;
      tick();
      din_valid = 1'b0;
      seen = 1'b0;
      guard = 0;
      while (guard < 1000) begin
         @(negedge clk);
         guard++;
         if (busy) begin
            seen = 1'b1;
            busy_n++;
         end else if (seen) break;
         if (prev_c && fsk_out !== prev_f) tog++;
         if (done) done_n++;
         if (bit_out) ones++;
         prev_c = busy && !done;
         prev_f = fsk_out;
      end
      check_int("byte_end_wait", int'(guard < 1000), 1);
   endtask

   typedef struct {
      logic [7:0] din;
      int         toggles;
      int         ones;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int tog, ones, busy_n, done_n;
      int hs_cyc[$];
      logic [7:0] hs_byte[$];
      int guard;

      tbl[0] = '{8'hFF, 128, 384};
      tbl[1] = '{8'h00,  64,   0};
      tbl[2] = '{8'h01,  72,  48};
      tbl[3] = '{8'h80,  72,  48};
      tbl[4] = '{8'hA5,  96, 192};
      tbl[5] = '{8'h3C,  96, 192};

      reset = 1'b1;
      din_valid = 1'b0;
      din = 8'h00;
      repeat (3) tick();
      chk_en = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      check_int("reset_state", int'({din_ready, busy, done, bit_out, fsk_out}), 16);

      // Directed bytes: toggle count, ones count, busy length, done pulses.
      for (int i = 0; i < 6; i++) begin
         send_byte(tbl[i].din, tog, ones, busy_n, done_n);
         check_int($sformatf("toggles_%02h", tbl[i].din), tog, tbl[i].toggles);
         check_int($sformatf("ones_%02h", tbl[i].din), ones, tbl[i].ones);
         check_int($sformatf("busy_len_%02h", tbl[i].din), busy_n, NB + 1);
         check_int($sformatf("done_pulses_%02h", tbl[i].din), done_n, 1);
         repeat (i) tick();
      end

      // din_valid held high: two handshakes 386 cycles apart.
      tick();
      din = 8'hA5;
      din_valid = 1'b1;
      guard = 0;
      while (hs_cyc.size() < 2 && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (din_ready && din_valid) begin
            hs_cyc.push_back(cyc);
            hs_byte.push_back(din);
         end
         tick();
         if (hs_cyc.size() == 1) din = 8'h3C;
      end
      din_valid = 1'b0;
      check_int("b2b_handshakes", hs_cyc.size(), 2);
      if (hs_cyc.size() == 2) begin
         check_int("b2b_spacing", hs_cyc[1] - hs_cyc[0], NB + 2);
         check_int("b2b_byte0", int'(hs_byte[0]), 8'hA5);
         check_int("b2b_byte1", int'(hs_byte[1]), 8'h3C);
      end
      repeat (NB + 4) tick();
      check_int("b2b_idle", int'(busy), 0);

      // Reset at SEND cycle 100 aborts the byte with no done pulse.
      din = 8'h5A;
      din_valid = 1'b1;
      @(negedge clk);
      tick();
      din_valid = 1'b0;
      repeat (100) tick();
      check_int("pre_abort_busy", int'(busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check_int("abort_state", int'({din_ready, busy, done, fsk_out}), 8);
      send_byte(8'h01, tog, ones, busy_n, done_n);
      check_int("post_abort_toggles", tog, 72);
      check_int("post_abort_done", done_n, 1);

      // Reset wins over a simultaneous handshake.
      tick();
      din = 8'h77;
      din_valid = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      din_valid = 1'b0;
      @(negedge clk);
      check_int("reset_vs_hs", int'({din_ready, busy}), 2);

      // din_valid pulses during SEND and DONE are ignored.
      din = 8'hC3;
      din_valid = 1'b1;
      @(negedge clk);
      tick();
      din_valid = 1'b0;
      guard = 0;
      while (guard < 1000) begin
         @(negedge clk);
         guard++;
         if (done) break;
         if (guard % 50 == 0) begin
            din = 8'hFF;
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
         end
      end
      check_int("done_seen", int'(done), 1);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      @(negedge clk);
      check_int("no_latch_in_done", int'({din_ready, busy}), 2);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 6000; n++) begin
         tick();
         din = 8'($urandom);
         din_valid = ($urandom % 4 == 0);
         reset = ($urandom % 700 == 0);
      end
      reset = 1'b0;
      din_valid = 1'b0;
      repeat (NB + 4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

endmodule
